// File: rtl/fp16_pkg.sv
// ============================================================================
// Module  : fp16_pkg
// Brief   : Shared types, FP16 field constants and NaN classifier.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fp16_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_FMA = 2'd3
    } fp16_opcode_e;

    localparam int          FP16_SIGN_BIT = 15;
    localparam int          FP16_EXP_MSB  = 14;
    localparam int          FP16_EXP_LSB  = 10;
    localparam int          FP16_MANT_MSB = 9;
    localparam logic [4:0]  EXP_MAX       = 5'h1F;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;

    function automatic logic fp16_is_nan(input logic [FP16_SIGN_BIT:0] x);
        return (x[FP16_EXP_MSB:FP16_EXP_LSB] == EXP_MAX) &&
               (x[FP16_MANT_MSB:0] != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp16_rr_arbiter.sv
// ============================================================================
// Module  : fp16_rr_arbiter
// Brief   : Two-way round-robin grant; combinational grant, registered pointer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp16_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       ptr_upd_i,
    input  logic       ptr_nxt_i,
    output logic [1:0] grant_o
);

    logic ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (ptr_upd_i) begin
            ptr_q <= ptr_nxt_i;
        end
    end

    // Pointer only matters when both requesters compete.
    always_comb begin
        grant_o = 2'b00;
        if (valid_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp16_unit_arbiter.sv
// ============================================================================
// Module  : fp16_unit_arbiter
// Brief   : Shares one multi-cycle FP16 unit between two requesters with a
//           watchdog. Optional NaN bypass enabled by FP16_NAN_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp16_unit_arbiter
    import fp16_pkg::*;
#(
    parameter int OPW            = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNTW           = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [15:0]     req0_op_a_i,
    input  logic [15:0]     req0_op_b_i,
    input  logic [15:0]     req1_op_a_i,
    input  logic [15:0]     req1_op_b_i,
    input  logic [OPW-1:0]  req0_opcode_i,
    input  logic [OPW-1:0]  req1_opcode_i,
    output logic            unit_start_o,
    output logic [15:0]     unit_op_a_o,
    output logic [15:0]     unit_op_b_o,
    output logic [OPW-1:0]  unit_opcode_o,
    input  logic            unit_done_i,
    input  logic [15:0]     unit_result_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [15:0]     rsp_result_o,
    output logic            rsp_err_o
);

    arb_state_e       state_q;
    logic [CNTW-1:0]  cnt_q;
    logic             unit_start_q;
    logic [15:0]      unit_op_a_q;
    logic [15:0]      unit_op_b_q;
    logic [OPW-1:0]   unit_opcode_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [15:0]      rsp_result_q;
    logic             rsp_err_q;

    logic [1:0]       w_grant;
    logic             w_sel_id;
    logic [15:0]      w_sel_a;
    logic [15:0]      w_sel_b;
    logic [OPW-1:0]   w_sel_opcode;
    logic             w_req_hs;
    logic             w_rsp_hs;
    logic             w_nan_byp;
    logic             w_timeout;

    fp16_rr_arbiter u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (req_valid_i),
        .ptr_upd_i (w_rsp_hs),
        .ptr_nxt_i (~rsp_id_q),
        .grant_o   (w_grant)
    );

    assign req_ready_o  = (state_q == ST_IDLE) ? w_grant : 2'b00;
    assign w_req_hs     = (state_q == ST_IDLE) && (w_grant != 2'b00);
    assign w_rsp_hs     = (state_q == ST_RESP) && rsp_ready_i;
    assign w_sel_id     = w_grant[1];
    assign w_sel_a      = w_sel_id ? req1_op_a_i   : req0_op_a_i;
    assign w_sel_b      = w_sel_id ? req1_op_b_i   : req0_op_b_i;
    assign w_sel_opcode = w_sel_id ? req1_opcode_i : req0_opcode_i;
    assign w_timeout    = (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

`ifdef FP16_NAN_BYPASS_EN
    assign w_nan_byp = fp16_is_nan(w_sel_a) || fp16_is_nan(w_sel_b);
`else
    assign w_nan_byp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            unit_start_q  <= 1'b0;
            unit_op_a_q   <= '0;
            unit_op_b_q   <= '0;
            unit_opcode_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        unit_op_a_q   <= w_sel_a;
                        unit_op_b_q   <= w_sel_b;
                        unit_opcode_q <= w_sel_opcode;
                        rsp_id_q      <= w_sel_id;
                        if (w_nan_byp) begin
                            rsp_result_q <= FP16_QNAN;
                            rsp_err_q    <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            unit_start_q <= 1'b1;
                            state_q      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    unit_start_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Completion takes precedence over a coincident timeout.
                    if (unit_done_i) begin
                        rsp_result_q <= unit_result_i;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (w_timeout) begin
                        rsp_result_q <= FP16_QNAN;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign unit_start_o  = unit_start_q;
    assign unit_op_a_o   = unit_op_a_q;
    assign unit_op_b_o   = unit_op_b_q;
    assign unit_opcode_o = unit_opcode_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_result_o  = rsp_result_q;
    assign rsp_err_o     = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fp16_unit_arbiter.sv
// ============================================================================
// Module  : tb_fp16_unit_arbiter
// Brief   : Directed + randomized self-checking bench for fp16_unit_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fp16_unit_arbiter;

    localparam int OPW = 2;
    localparam int TO  = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [15:0]     req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
    logic [OPW-1:0]  req0_opcode = '0, req1_opcode = '0;
    logic            unit_start;
    logic [15:0]     unit_op_a, unit_op_b;
    logic [OPW-1:0]  unit_opcode;
    logic            unit_done = 1'b0;
    logic [15:0]     unit_result = 16'hDEAD;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [15:0]     rsp_result;
    logic            rsp_err;

    always #5 clk = ~clk;

    fp16_unit_arbiter #(.OPW(OPW), .TIMEOUT_CYCLES(TO), .CNTW(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req0_op_a_i   (req0_op_a),
        .req0_op_b_i   (req0_op_b),
        .req1_op_a_i   (req1_op_a),
        .req1_op_b_i   (req1_op_b),
        .req0_opcode_i (req0_opcode),
        .req1_opcode_i (req1_opcode),
        .unit_start_o  (unit_start),
        .unit_op_a_o   (unit_op_a),
        .unit_op_b_o   (unit_op_b),
        .unit_opcode_o (unit_opcode),
        .unit_done_i   (unit_done),
        .unit_result_i (unit_result),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_result_o  (rsp_result),
        .rsp_err_o     (rsp_err)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ptr_m  = 0;
    int last_g = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic bit is_nan_m(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b11) return ptr_m;
        return v[1] ? 1 : 0;
    endfunction

    task automatic rand_ops();
        req0_op_a   = 16'($urandom);
        req0_op_b   = 16'($urandom);
        req1_op_a   = 16'($urandom);
        req1_op_b   = 16'($urandom);
        req0_opcode = OPW'($urandom);
        req1_opcode = OPW'($urandom);
        if ($urandom_range(0, 5) == 0) req0_op_b = 16'h7D55;
        if ($urandom_range(0, 5) == 0) req1_op_a = 16'hFE01;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        unit_done = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    // dly < 0 means the unit never answers; res is the unit's result otherwise.
    task automatic do_txn(input logic [1:0] v, input int dly, input int hold, input logic [15:0] res);
        int g, c;
        logic [15:0] a, b, er;
        logic [OPW-1:0] oc;
        bit byp, ee;
        req_valid = v;
        g  = exp_grant(v);
        a  = (g == 1) ? req1_op_a   : req0_op_a;
        b  = (g == 1) ? req1_op_b   : req0_op_b;
        oc = (g == 1) ? req1_opcode : req0_opcode;
        byp = 1'b0;
`ifdef FP16_NAN_BYPASS_EN
        byp = is_nan_m(a) || is_nan_m(b);
`endif
        last_g = g;
        #1;
        chk("req_ready", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
        tick();
        chk("unit_start_c1", 32'(unit_start), byp ? 32'd0 : 32'd1);
        if (byp) begin
            er = 16'h7E00;
            ee = 1'b0;
        end else begin
            chk("unit_op_a", 32'(unit_op_a), 32'(a));
            chk("unit_op_b", 32'(unit_op_b), 32'(b));
            chk("unit_opcode", 32'(unit_opcode), 32'(oc));
            tick();
            chk("unit_start_c2", 32'(unit_start), 32'd0);
            if (dly < 0) begin
                c = 2;
                while (!rsp_valid && c < 200) begin
                    tick();
                    c++;
                end
                chk("timeout_latency", 32'(c), 32'(2 + TO));
                er = 16'h7E00;
                ee = 1'b1;
            end else begin
                for (int i = 0; i < dly; i++) begin
                    tick();
                    chk("no_early_rsp", 32'(rsp_valid), 32'd0);
                end
                unit_done   = 1'b1;
                unit_result = res;
                tick();
                unit_done   = 1'b0;
                unit_result = 16'hDEAD;
                er = res;
                ee = 1'b0;
            end
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_result", 32'(rsp_result), 32'(er));
        chk("rsp_err", 32'(rsp_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            unit_done   = 1'($urandom);
            unit_result = 16'($urandom);
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_result", 32'(rsp_result), 32'(er));
            chk("hold_err", 32'(rsp_err), 32'(ee));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_no_start", 32'(unit_start), 32'd0);
        end
        unit_done   = 1'b0;
        unit_result = 16'hDEAD;
        rsp_ready   = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        ptr_m = 1 - g;
    endtask

    initial begin
        // Reset state
        apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_unit_start", 32'(unit_start), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_op_a", 32'(unit_op_a), 32'd0);
        chk("rst_op_b", 32'(unit_op_b), 32'd0);
        chk("rst_opcode", 32'(unit_opcode), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        apply_reset();

        // Single REQ0 transaction, unit answers in cycle 4
        req0_op_a = 16'h3C00; req0_op_b = 16'h4000; req0_opcode = 2'd0;
        do_txn(2'b01, 2, 0, 16'h4200);

        // Round-robin with both requesters continuously valid
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            req0_op_a = 16'h3C00; req0_op_b = 16'h4400;
            req1_op_a = 16'hC000; req1_op_b = 16'h3800;
            do_txn(2'b11, i, 0, 16'($urandom));
            chk("rr_order", 32'(last_g), 32'(i % 2));
        end

        // Watchdog timeout on REQ1
        req1_op_a = 16'h3C00; req1_op_b = 16'h4000; req1_opcode = 2'd2;
        do_txn(2'b10, -1, 0, 16'h0000);

        // Response back-pressure for 10 cycles, REQ1 left waiting
        req0_op_a = 16'h4500; req0_op_b = 16'h3555;
        req1_op_a = 16'h4000; req1_op_b = 16'h4000;
        do_txn(2'b11, 1, 10, 16'h4A00);

        // Reset while waiting on the unit
        req0_op_a = 16'h3C00; req0_op_b = 16'h3C00;
        req1_op_a = 16'h3C00; req1_op_b = 16'h3C00;
        req_valid = 2'b11;
        #1;
        chk("pre_rst_grant", 32'(req_ready), (ptr_m == 1) ? 32'd2 : 32'd1);
        tick();
        chk("pre_rst_start", 32'(unit_start), 32'd1);
        tick();
        tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("midrst_start", 32'(unit_start), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        do_txn(2'b11, 0, 0, 16'h1234);
        chk("post_rst_grant0", 32'(last_g), 32'd0);

        // NaN operand on REQ0
        req0_op_a = 16'h7C01; req0_op_b = 16'h3C00;
        do_txn(2'b01, 1, 1, 16'h5555);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            rand_ops();
            do_txn(v, $urandom_range(0, 4), $urandom_range(0, 2), 16'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
